// File: rtl/alu_iterative.sv
// Execute-stage ALU: single-cycle AND/OR/ADD/SUB and an iterative shift-add MUL
// that takes WIDTH clocks, with a start/busy/valid handshake and a flush abort.
module alu_iterative #(
  parameter int WIDTH = 32,
  parameter int CW    = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             dbg_state_o
);

  // Handshake: start_i is accepted only on an edge where the FSM is IDLE and
  // flush_i is low; busy_o high means any start_i is ignored; valid_o pulses
  // for exactly one cycle on the edge that updates data_o/zero_o.
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b011;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t           state_q, state_n;
  logic [WIDTH-1:0] acc_q, acc_n;
  logic [WIDTH-1:0] mcand_q, mcand_n;
  logic [WIDTH-1:0] mplier_q, mplier_n;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic [WIDTH-1:0] data_q, data_n;
  logic             zero_q, zero_n;
  logic             valid_q, valid_n;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] acc_sum;

  always_comb begin
    alu_res = '0;
    case (ALUCtrl_i)
      OP_AND:  alu_res = data1_i & data2_i;
      OP_OR:   alu_res = data1_i | data2_i;
      OP_ADD:  alu_res = data1_i + data2_i;
      OP_SUB:  alu_res = data1_i - data2_i;
      default: alu_res = '0;
    endcase
  end

  // Accumulator value including the current iteration's partial product.
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_n  = state_q;
    acc_n    = acc_q;
    mcand_n  = mcand_q;
    mplier_n = mplier_q;
    cnt_n    = cnt_q;
    data_n   = data_q;
    zero_n   = zero_q;
    valid_n  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!flush_i && start_i) begin
          if (ALUCtrl_i == OP_MUL) begin
            mcand_n  = data1_i;
            mplier_n = data2_i;
            acc_n    = '0;
            cnt_n    = '0;
            state_n  = MUL;
          end else begin
            data_n  = alu_res;
            zero_n  = (alu_res == '0);
            valid_n = 1'b1;
          end
        end
      end
      MUL: begin
        if (flush_i) begin
          state_n = IDLE;
        end else begin
          acc_n    = acc_sum;
          mcand_n  = mcand_q << 1;
          mplier_n = mplier_q >> 1;
          cnt_n    = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            data_n  = acc_sum;
            zero_n  = (acc_sum == '0);
            valid_n = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      zero_q   <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_n;
      acc_q    <= acc_n;
      mcand_q  <= mcand_n;
      mplier_q <= mplier_n;
      cnt_q    <= cnt_n;
      data_q   <= data_n;
      zero_q   <= zero_n;
      valid_q  <= valid_n;
    end
  end

  assign data_o      = data_q;
  assign zero_o      = zero_q;
  assign valid_o     = valid_q;
  assign busy_o      = (state_q == MUL);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_iterative.sv
// Bench for alu_iterative: directed cases from the test plan followed by random
// operations, all checked against a plain-arithmetic reference and an expected queue.
module tb_alu_iterative;

  localparam int W  = 32;
  localparam int CW = 6;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b011;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         start_i;
  logic         flush_i;
  logic [2:0]   ALUCtrl_i;
  logic [W-1:0] data1_i;
  logic [W-1:0] data2_i;
  logic [W-1:0] data_o;
  logic         zero_o;
  logic         valid_o;
  logic         busy_o;
  logic         dbg_state_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] cur_data;

  alu_iterative #(.WIDTH(W), .CW(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .flush_i(flush_i),
    .ALUCtrl_i(ALUCtrl_i), .data1_i(data1_i), .data2_i(data2_i),
    .data_o(data_o), .zero_o(zero_o), .valid_o(valid_o), .busy_o(busy_o),
    .dbg_state_o(dbg_state_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: the operation's meaning in plain arithmetic, modulo 2^W.
  function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_MUL:  r = a * b;
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs == exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Launch one operation and follow it to completion; returns in the valid cycle
  // so the next call starts back-to-back.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit disturb);
    logic [W-1:0] e;
    int busy_cycles;
    int valid_seen;
    exp_q.push_back(model(op, a, b));
    ALUCtrl_i = op; data1_i = a; data2_i = b; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    if (op == OP_MUL) begin
      busy_cycles = busy_o ? 1 : 0;
      valid_seen  = valid_o ? 1 : 0;
      for (int i = 0; i < W - 1; i++) begin
        if (disturb) begin
          data1_i = $urandom; data2_i = $urandom;
          ALUCtrl_i = 3'($urandom_range(0, 7));
          start_i = 1'($urandom_range(0, 1));
        end
        tick();
        if (busy_o) busy_cycles++;
        if (valid_o) valid_seen++;
      end
      start_i = 1'b0;
      check_int("mul_busy_cycles", busy_cycles, W);
      check_int("mul_early_valid", valid_seen, 0);
      tick();
    end
    e = exp_q.pop_front();
    check_bit("op_valid", valid_o, 1'b1);
    check_bit("op_busy_done", busy_o, 1'b0);
    check("op_data", data_o, e);
    check_bit("op_zero", zero_o, (e == '0));
    cur_data = e;
  endtask

  task automatic idle_check();
    tick();
    check_bit("idle_valid", valid_o, 1'b0);
    check_bit("idle_busy", busy_o, 1'b0);
    check("idle_hold", data_o, cur_data);
  endtask

  initial begin
    logic [2:0] codes [8];
    int valid_seen;
    codes = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_MUL, 3'b100, 3'b101, 3'b111};
    rst_i = 1'b0; start_i = 1'b0; flush_i = 1'b0;
    ALUCtrl_i = '0; data1_i = '0; data2_i = '0; cur_data = '0;
    repeat (2) tick();
    check("rst_data", data_o, '0);
    check_bit("rst_zero", zero_o, 1'b1);
    check_bit("rst_valid", valid_o, 1'b0);
    check_bit("rst_busy", busy_o, 1'b0);
    rst_i = 1'b1;
    tick();

    run_op(OP_ADD, 32'd5, 32'd7, 0);
    idle_check();
    run_op(OP_SUB, 32'd9, 32'd9, 0);
    run_op(OP_SUB, 32'd0, 32'd1, 0);
    idle_check();
    run_op(OP_MUL, 32'h0000_1234, 32'h0000_0010, 1);
    idle_check();
    run_op(OP_MUL, 32'hFFFF_FFFF, 32'h0000_0003, 0);
    run_op(OP_ADD, 32'd3, 32'd4, 0);
    run_op(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
    run_op(OP_OR,  32'hF0F0_F0F0, 32'hFF00_FF00, 0);
    run_op(3'b111, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
    idle_check();
    run_op(OP_ADD, 32'd100, 32'd23, 0);
    idle_check();

    // Flush at iteration 10: no completion, data keeps the previous result.
    ALUCtrl_i = OP_MUL; data1_i = 32'd6; data2_i = 32'd7; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (9) tick();
    check_bit("flush_pre_busy", busy_o, 1'b1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check_bit("flush_busy", busy_o, 1'b0);
    check_bit("flush_valid", valid_o, 1'b0);
    check("flush_hold", data_o, cur_data);
    valid_seen = 0;
    repeat (30) begin
      tick();
      if (valid_o) valid_seen++;
    end
    check_int("flush_no_valid", valid_seen, 0);

    // Asynchronous reset at iteration 10.
    ALUCtrl_i = OP_MUL; data1_i = 32'd6; data2_i = 32'd7; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (9) tick();
    rst_i = 1'b0;
    #1;
    check("arst_data", data_o, '0);
    check_bit("arst_zero", zero_o, 1'b1);
    check_bit("arst_valid", valid_o, 1'b0);
    check_bit("arst_busy", busy_o, 1'b0);
    tick();
    rst_i = 1'b1;
    cur_data = '0;
    idle_check();

    // Flush while idle drops a start.
    ALUCtrl_i = OP_ADD; data1_i = 32'd1; data2_i = 32'd1; start_i = 1'b1; flush_i = 1'b1;
    tick();
    start_i = 1'b0; flush_i = 1'b0;
    check_bit("iflush_valid", valid_o, 1'b0);
    check("iflush_hold", data_o, cur_data);
    check_bit("iflush_busy", busy_o, 1'b0);

    for (int k = 0; k < 40; k++) begin
      run_op(codes[$urandom_range(0, 7)], $urandom, $urandom, ($urandom_range(0, 1) == 1));
      if ($urandom_range(0, 2) == 0) idle_check();
    end
    idle_check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_iterative.md
Name: alu_iterative

Overview:
- Execute-stage ALU of the CPU datapath. Sits directly downstream of the ALU control decoder and consumes its 3-bit ALUCtrl code.
- AND/OR/ADD/SUB complete in one clock.
- MUL runs as an iterative shift-add over WIDTH clocks.
- A start/busy/valid handshake lets the pipeline stall during a multiply.

Parameters:
- WIDTH, 32, operand and result width in bits. Also the MUL iteration count.
- CW, 6, width of the internal iteration counter. Must satisfy 2^CW > WIDTH.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- start_i  input  1  launch an operation. Sampled only when the FSM is in IDLE.
- flush_i  input  1  synchronous abort of an in-flight MUL.
- ALUCtrl_i  input  3  operation code from the ALU control decoder.
- data1_i  input  WIDTH  operand A (rs).
- data2_i  input  WIDTH  operand B (rt or sign-extended immediate).
- data_o  output  WIDTH  registered result.
- zero_o  output  1  registered; equals (data_o == 0).
- valid_o  output  1  one-cycle pulse: data_o has just been updated.
- busy_o  output  1  high while a MUL is in progress; the pipeline stalls on it.

Behaviour:
- Opcode encoding of ALUCtrl_i:
  - 3'b000 AND
  - 3'b001 OR
  - 3'b010 ADD
  - 3'b110 SUB
  - 3'b011 MUL
  - Any other code produces result 0 with single-cycle timing.
- Reset (rst_i low, asynchronous):
  - State = IDLE.
  - data_o = 0, zero_o = 1, valid_o = 0, busy_o = 0.
  - Internal accumulator, multiplicand, multiplier and counter = 0.
- FSM states are IDLE and MUL. busy_o = (state == MUL), decoded from the state register.
- IDLE, start_i = 1, non-MUL code:
  - At that edge, data_o takes the result, zero_o is updated and valid_o = 1 for one cycle. Latency is 1 edge.
  - State stays IDLE.
- IDLE, start_i = 1, ALUCtrl_i = MUL:
  - At that edge: latch multiplicand = data1_i, multiplier = data2_i, accumulator = 0, counter = 0.
  - State goes to MUL. valid_o = 0.
- MUL state, each edge:
  - If multiplier[0] = 1, accumulator += multiplicand.
  - Then multiplicand <<= 1, multiplier >>= 1, counter++.
  - On the edge where counter == WIDTH-1 (the WIDTH-th iteration): data_o = final accumulator, zero_o is updated, valid_o = 1, state goes to IDLE.
  - MUL result therefore appears WIDTH edges after the start edge; busy_o is high for exactly WIDTH cycles.
- Arithmetic rules:
  - All arithmetic is modulo 2^WIDTH, with no overflow or carry flag.
  - The MUL result is the low WIDTH bits of the product. This is identical for signed and unsigned operands.
  - SUB computes data1_i - data2_i.
- Operand capture:
  - Operands and ALUCtrl_i are captured at the start edge only.
  - Changes on the inputs during MUL have no effect.
- start_i while in MUL is ignored: no queuing, and no effect on the outputs.
- Back-to-back operation: start_i in the same cycle that valid_o is high is accepted, since the state is already IDLE.
- valid_o is cleared on every edge where no completion occurs.
- data_o and zero_o hold their last value until the next completion.
- flush_i:
  - In MUL: at the edge, state goes to IDLE, valid_o = 0, data_o is unchanged and the partial result is discarded.
  - flush_i has priority over completion on the same edge.
  - In IDLE, flush_i has priority over start_i: the start is dropped and valid_o = 0.
- Reset asserted mid-MUL aborts immediately, with the reset values applied asynchronously.

Test Plan:
- Reset, then ADD with data1 = 5, data2 = 7 → one edge later: data_o = 12, valid_o pulses for 1 cycle, busy_o stays 0, zero_o = 0.
- SUB with 9 and 9 → data_o = 0, zero_o = 1. SUB with 0 and 1 → data_o = 0xFFFFFFFF (wrap-around).
- MUL with 0x0000_1234 and 0x0000_0010:
  - busy_o is high for exactly 32 cycles.
  - valid_o rises 32 edges after start, with data_o = 0x0001_2340.
  - A start_i pulse mid-operation is ignored.
- MUL with 0xFFFF_FFFF (-1) and 0x0000_0003 → data_o = 0xFFFF_FFFD. Then ADD issued in the valid_o cycle → accepted, and its result appears on the next edge.
- MUL with 6 and 7:
  - Assert flush_i at iteration 10 → busy_o drops the next cycle, there is no valid_o, and data_o retains the prior value.
  - Repeat with rst_i low at iteration 10 → all outputs go to their reset values immediately.
- AND/OR with 0xF0F0_F0F0 and 0xFF00_FF00 → AND = 0xF000_F000 and OR = 0xFFF0_FFF0. Code 3'b111 → data_o = 0, zero_o = 1.
